// File: rtl/aig_truth_table_sweeper.sv
// aig_truth_table_sweeper: drives every input vector onto a small AIG netlist, captures its truth table, compares with expected.
// Rev 1.0
`default_nettype none

module aig_truth_table_sweeper #(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 6,
  parameter int SETTLE = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  output logic [N_IN-1:0]               x,
  input  logic [N_OUT-1:0]              f,
  input  logic [N_OUT*(2**N_IN)-1:0]    exp_tt,
  output logic [N_OUT*(2**N_IN)-1:0]    tt,
  output logic [N_IN-1:0]               vec_idx,
  output logic                          busy,
  output logic                          done,
  output logic                          match
);

  localparam int N_VEC = 2**N_IN;
  localparam int TT_W  = N_OUT * N_VEC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    CAPT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [N_IN:0] LAST_VEC    = N_VEC - 1;
  localparam logic [N_IN:0] CNT_ONE     = 1;
  localparam logic [3:0]    SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
  // With no settle time each vector is captured in the cycle it is applied.
  localparam state_t        FIRST_STATE = (SETTLE == 0) ? CAPT : WAIT;

  state_t          state, state_nxt;
  logic [N_IN:0]   cnt, cnt_nxt;
  logic [3:0]      settle, settle_nxt;
  logic [TT_W-1:0] tt_nxt;
  logic            match_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      settle <= '0;
      tt     <= '0;
      match  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      settle <= settle_nxt;
      tt     <= tt_nxt;
      match  <= match_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    settle_nxt = settle;
    tt_nxt     = tt;
    match_nxt  = match;

    if ((state == WAIT || state == CAPT) && abort) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      match_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            cnt_nxt    = '0;
            settle_nxt = '0;
            match_nxt  = 1'b0;
            state_nxt  = FIRST_STATE;
          end
        end
        WAIT: begin
          settle_nxt = settle + 4'd1;
          if (settle == SETTLE_LAST) state_nxt = CAPT;
        end
        CAPT: begin
          for (int i = 0; i < N_VEC; i++) begin
            if (cnt[N_IN-1:0] == N_IN'(i)) tt_nxt[i*N_OUT +: N_OUT] = f;
          end
          if (cnt == LAST_VEC) begin
            // Compare against the table including the entry written this cycle.
            match_nxt = (tt_nxt == exp_tt);
            state_nxt = DONE;
          end else begin
            cnt_nxt    = cnt + CNT_ONE;
            settle_nxt = '0;
            state_nxt  = FIRST_STATE;
          end
        end
        DONE: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign x       = cnt[N_IN-1:0];
  assign vec_idx = cnt[N_IN-1:0];
  assign busy    = (state == WAIT) || (state == CAPT);
  assign done    = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_aig_truth_table_sweeper.sv
// tb_aig_truth_table_sweeper: directed checks of the sweeper with SETTLE=1, 0 and 3 against f = {3'b000, x}.
// Rev 1.0
`default_nettype none

module tb_aig_truth_table_sweeper;

  localparam logic [47:0] GOLD = 48'h1C61440C2040;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_d = 1'b0, abort_d = 1'b0;
  logic        start_z = 1'b0, abort_z = 1'b0;
  logic        start_s = 1'b0, abort_s = 1'b0;
  logic [47:0] exp_d = GOLD, exp_z = GOLD, exp_s = GOLD;

  logic [2:0]  x_d, x_z, x_s, vi_d, vi_z, vi_s;
  logic [5:0]  f_d, f_z, f_s;
  logic [47:0] tt_d, tt_z, tt_s;
  logic        busy_d, busy_z, busy_s, done_d, done_z, done_s, match_d, match_z, match_s;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign f_d = {3'b000, x_d};
  assign f_z = {3'b000, x_z};
  assign f_s = {3'b000, x_s};

  aig_truth_table_sweeper #(.N_IN(3), .N_OUT(6), .SETTLE(1)) u_d (
    .clk(clk), .rst(rst), .start(start_d), .abort(abort_d), .x(x_d), .f(f_d),
    .exp_tt(exp_d), .tt(tt_d), .vec_idx(vi_d), .busy(busy_d), .done(done_d), .match(match_d));

  aig_truth_table_sweeper #(.N_IN(3), .N_OUT(6), .SETTLE(0)) u_z (
    .clk(clk), .rst(rst), .start(start_z), .abort(abort_z), .x(x_z), .f(f_z),
    .exp_tt(exp_z), .tt(tt_z), .vec_idx(vi_z), .busy(busy_z), .done(done_z), .match(match_z));

  aig_truth_table_sweeper #(.N_IN(3), .N_OUT(6), .SETTLE(3)) u_s (
    .clk(clk), .rst(rst), .start(start_s), .abort(abort_s), .x(x_s), .f(f_s),
    .exp_tt(exp_s), .tt(tt_s), .vec_idx(vi_s), .busy(busy_s), .done(done_s), .match(match_s));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full sweep on the SETTLE=1 instance; returns in the DONE cycle.
  task automatic run_sweep(input string tag, input logic want_match);
    start_d = 1'b1;
    tick();
    start_d = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check({tag, " x"}, 64'(x_d), 64'(k / 2));
      check({tag, " vec_idx"}, 64'(vi_d), 64'(k / 2));
      check({tag, " busy"}, 64'(busy_d), 64'd1);
      check({tag, " done_early"}, 64'(done_d), 64'd0);
      tick();
    end
    check({tag, " done"}, 64'(done_d), 64'd1);
    check({tag, " busy_in_done"}, 64'(busy_d), 64'd0);
    check({tag, " x_in_done"}, 64'(x_d), 64'd7);
    check({tag, " tt"}, 64'(tt_d), 64'(GOLD));
    check({tag, " match"}, 64'(match_d), 64'(want_match));
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("reset x", 64'(x_d), 64'd0);
      check("reset tt", 64'(tt_d), 64'd0);
      check("reset busy", 64'(busy_d), 64'd0);
      check("reset done", 64'(done_d), 64'd0);
      check("reset match", 64'(match_d), 64'd0);
      tick();
    end
    check("reset tt_z", 64'(tt_z), 64'd0);
    check("reset tt_s", 64'(tt_s), 64'd0);

    // Abort together with start in IDLE: no sweep.
    start_d = 1'b1; abort_d = 1'b1;
    tick();
    start_d = 1'b0; abort_d = 1'b0;
    check("abort_wins busy", 64'(busy_d), 64'd0);

    exp_d = GOLD;
    run_sweep("sweep1", 1'b1);
    tick();
    check("post done", 64'(done_d), 64'd0);
    check("post x", 64'(x_d), 64'd0);
    check("post tt hold", 64'(tt_d), 64'(GOLD));
    check("post match hold", 64'(match_d), 64'd1);

    exp_d = GOLD ^ 48'd1;
    run_sweep("sweep_bad", 1'b0);
    tick();
    check("bad match hold", 64'(match_d), 64'd0);

    start_z = 1'b1;
    tick();
    start_z = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("s0 x", 64'(x_z), 64'(k));
      check("s0 done_early", 64'(done_z), 64'd0);
      tick();
    end
    check("s0 done", 64'(done_z), 64'd1);
    check("s0 tt", 64'(tt_z), 64'(GOLD));
    check("s0 match", 64'(match_z), 64'd1);
    tick();

    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    for (int k = 0; k < 32; k++) begin
      check("s3 x", 64'(x_s), 64'(k / 4));
      check("s3 done_early", 64'(done_s), 64'd0);
      tick();
    end
    check("s3 done", 64'(done_s), 64'd1);
    check("s3 tt", 64'(tt_s), 64'(GOLD));
    check("s3 match", 64'(match_s), 64'd1);
    tick();

    // Start in DONE is dropped; start in the following IDLE cycle is taken.
    exp_d = GOLD;
    run_sweep("sweep_dn", 1'b1);
    start_d = 1'b1;
    tick();
    check("start_in_done ignored", 64'(busy_d), 64'd0);
    check("start_in_done x", 64'(x_d), 64'd0);
    tick();
    start_d = 1'b0;
    check("restart busy", 64'(busy_d), 64'd1);
    check("restart x", 64'(x_d), 64'd0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("restart done", 64'(done_d), 64'(k == 16));
    end
    check("restart match", 64'(match_d), 64'd1);
    tick();

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst clears tt", 64'(tt_d), 64'd0);

    start_d = 1'b1;
    tick();
    start_d = 1'b0;
    repeat (8) tick();
    check("pre_abort x", 64'(x_d), 64'd4);
    check("pre_abort busy", 64'(busy_d), 64'd1);
    abort_d = 1'b1;
    tick();
    abort_d = 1'b0;
    check("abort x", 64'(x_d), 64'd0);
    check("abort busy", 64'(busy_d), 64'd0);
    check("abort done", 64'(done_d), 64'd0);
    check("abort match", 64'(match_d), 64'd0);
    check("abort tt", 64'(tt_d), 64'(48'h0000000C2040));
    for (int k = 0; k < 3; k++) begin
      tick();
      check("abort idle done", 64'(done_d), 64'd0);
      check("abort idle busy", 64'(busy_d), 64'd0);
    end

    start_d = 1'b1;
    tick();
    start_d = 1'b0;
    repeat (10) tick();
    check("pre_rst x", 64'(x_d), 64'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst x", 64'(x_d), 64'd0);
    check("midrst tt", 64'(tt_d), 64'd0);
    check("midrst busy", 64'(busy_d), 64'd0);
    check("midrst done", 64'(done_d), 64'd0);
    check("midrst match", 64'(match_d), 64'd0);
    run_sweep("sweep_after_rst", 1'b1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
